// File: rtl/fp_pkg.sv
// fp_pkg: shared op encodings, operand class struct and canonical-NaN builder
package fp_pkg;
   typedef enum logic [1:0] {
      OP_FMIN   = 2'b00,
      OP_FMAX   = 2'b01,
      OP_REDMIN = 2'b10,
      OP_REDMAX = 2'b11
   } op_e;
   typedef struct packed {
      logic sign;
      logic is_nan;
      logic is_snan;
      logic is_zero;
   } fp_class_t;
   // Canonical quiet NaN: sign 0, exponent all-ones, only mantissa MSB set.
   // Callers truncate the 64-bit result to their own format width.
   function automatic logic [63:0] canon_nan(input int exp_w, input int man_w);
      logic [63:0] r;
      r = '0;
      for (int i = 0; i < exp_w; i++) r[man_w+i] = 1'b1;
      r[man_w-1] = 1'b1;
      return r;
   endfunction
endpackage

// File: rtl/fminmax_pipe_if.sv
// fminmax_pipe_if: operand/result handshake bundle
//   master drives in_valid/op/a/b/last/out_ready; slave drives in_ready/out_valid/result/nv
interface fminmax_pipe_if #(parameter int WIDTH = 32);
   logic             in_valid, in_ready, last, out_valid, out_ready, nv;
   logic [1:0]       op;
   logic [WIDTH-1:0] a, b, result;
   modport master (output in_valid, op, a, b, last, out_ready,
                   input  in_ready, out_valid, result, nv);
   modport slave  (input  in_valid, op, a, b, last, out_ready,
                   output in_ready, out_valid, result, nv);
endinterface

// File: rtl/fp_classify.sv
// fp_classify: combinational operand classifier
//   x: floating-point operand; cls: sign, NaN, signalling NaN and zero flags
module fp_classify import fp_pkg::*; #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic [EXP_W+MAN_W:0] x,
   output fp_class_t            cls
);
   logic exp_ones, exp_zero, man_zero;
   assign exp_ones = &x[EXP_W+MAN_W-1:MAN_W];
   assign exp_zero = ~|x[EXP_W+MAN_W-1:MAN_W];
   assign man_zero = ~|x[MAN_W-1:0];
   assign cls = fp_class_t'{
      sign:    x[EXP_W+MAN_W],
      is_nan:  exp_ones & ~man_zero,
      is_snan: exp_ones & ~man_zero & ~x[MAN_W-1],
      is_zero: exp_zero & man_zero
   };
endmodule

// File: rtl/fminmax_pipe.sv
// fminmax_pipe: 2-stage floating-point min/max with streaming min/max reduction
//   clk/rst: clock and async active-high reset
//   bus (slave): in_valid/in_ready/op/a/b/last operand side, out_valid/out_ready/result/nv result side
module fminmax_pipe import fp_pkg::*; #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input logic           clk,
   input logic           rst,
   fminmax_pipe_if.slave bus
);
   localparam int WIDTH = 1 + EXP_W + MAN_W;
   localparam logic [WIDTH-1:0] QNAN = WIDTH'(canon_nan(EXP_W, MAN_W));
   fp_class_t        ca, cb, s1_ca, s1_cb, xc, yc;
   op_e              s1_op;
   logic [WIDTH-1:0] s1_a, s1_b, acc, res, x, y, mm;
   logic             s1_valid, s1_last, s2_valid, acc_nv, acc_nan, res_nv;
   logic             s1_advance, red, sel_max, x_lt_y, y_lt_x, emit, mm_nv;
   fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_a (.x(bus.a), .cls(ca));
   fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_b (.x(bus.b), .cls(cb));
   assign s1_advance    = ~s2_valid | bus.out_ready;
   assign bus.in_ready  = ~s1_valid | s1_advance;
   assign bus.out_valid = s2_valid;
   assign bus.result    = res;
   assign bus.nv        = res_nv;
   // acc only ever holds the canonical qNaN or a non-NaN value, so it can never be signalling
   assign acc_nan = &acc[WIDTH-2:MAN_W] & |acc[MAN_W-1:0];
   // Reductions compare (acc, a); pairwise ops compare (a, b). x is the operand kept on ties.
   always_comb begin
      red     = (s1_op == OP_REDMIN) || (s1_op == OP_REDMAX);
      sel_max = (s1_op == OP_FMAX) || (s1_op == OP_REDMAX);
      x       = red ? acc : s1_a;
      y       = red ? s1_a : s1_b;
      xc      = red ? fp_class_t'{sign: acc[WIDTH-1], is_nan: acc_nan, is_snan: 1'b0,
                                  is_zero: ~|acc[WIDTH-2:0]} : s1_ca;
      yc      = red ? s1_ca : s1_cb;
      // Sign decides first (so -0 < +0); same sign compares magnitude, reversed when negative.
      x_lt_y  = (xc.sign != yc.sign) ? xc.sign :
                (xc.is_zero & yc.is_zero) ? 1'b0 :
                xc.sign ? (x[WIDTH-2:0] > y[WIDTH-2:0]) : (x[WIDTH-2:0] < y[WIDTH-2:0]);
      y_lt_x  = (xc.sign != yc.sign) ? yc.sign :
                (xc.is_zero & yc.is_zero) ? 1'b0 :
                yc.sign ? (y[WIDTH-2:0] > x[WIDTH-2:0]) : (y[WIDTH-2:0] < x[WIDTH-2:0]);
      mm      = (xc.is_nan & yc.is_nan) ? QNAN :
                xc.is_nan ? y :
                yc.is_nan ? x :
                (sel_max ? x_lt_y : y_lt_x) ? y : x;
      mm_nv   = (red & acc_nv) | xc.is_snan | yc.is_snan;
      emit    = ~red | s1_last;
   end
   always_ff @(posedge clk) begin
      if (bus.in_ready) begin
         s1_op   <= op_e'(bus.op);
         s1_a    <= bus.a;
         s1_b    <= bus.b;
         s1_last <= bus.last;
         s1_ca   <= ca;
         s1_cb   <= cb;
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
         res      <= '0;
         res_nv   <= 1'b0;
         acc      <= QNAN;
         acc_nv   <= 1'b0;
      end else begin
         if (bus.in_ready) s1_valid <= bus.in_valid;
         if (s1_advance) begin
            s2_valid <= s1_valid & emit;
            if (s1_valid & emit) begin
               res    <= mm;
               res_nv <= mm_nv;
            end
            // A last beat emits and restarts the reduction in the same cycle.
            if (s1_valid & red) begin
               acc    <= s1_last ? QNAN : mm;
               acc_nv <= ~s1_last & mm_nv;
            end
         end
      end
   end
endmodule

// File: doc/fminmax_pipe.md
FMINMAX_PIPE -- requirements
Module: fminmax_pipe

Interface
REQ-001 SHALL have parameter EXP_W, 8, exponent field width.
REQ-002 SHALL have parameter MAN_W, 23, mantissa field width; WIDTH = 1+EXP_W+MAN_W (32 by default) is derived.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  operand beat offered.
REQ-006 SHALL have port in_ready  output  1  beat accepted when in_valid&in_ready.
REQ-007 SHALL have port op  input  2  00 FMIN, 01 FMAX, 10 REDMIN, 11 REDMAX.
REQ-008 SHALL have port a  input  WIDTH  first operand / reduction element.
REQ-009 SHALL have port b  input  WIDTH  second operand; ignored for REDMIN/REDMAX.
REQ-010 SHALL have port last  input  1  final element of a reduction; ignored for FMIN/FMAX.
REQ-011 SHALL have port out_valid  output  1  result available.
REQ-012 SHALL have port out_ready  input  1  consumer accepts when out_valid&out_ready.
REQ-013 SHALL have port result  output  WIDTH  min/max result.
REQ-014 SHALL have port nv  output  1  invalid-operation flag paired with result.

Function
REQ-015 SHALL classify each operand: NaN = exp all-ones & mantissa!=0; sNaN = NaN & mantissa MSB 0; zero = exp 0 & mantissa 0.
REQ-016 SHALL order values totally with -0 < +0; same-sign compare by {exp,mantissa} magnitude, reversed for negative.
REQ-017 SHALL return canonical qNaN (sign 0, exp all-ones, mantissa MSB 1, rest 0; 0x7FC00000 default) when both inputs NaN.
REQ-018 SHALL return the non-NaN operand when exactly one input is NaN.
REQ-019 SHALL return a when operands compare equal (bit-identical result for equal non-zero values).
REQ-020 SHALL set nv when any compared operand is sNaN; qNaN alone SHALL NOT set nv.
REQ-021 SHALL be a 2-stage pipeline: stage 1 registers operands+classification, stage 2 compares and registers result; FMIN/FMAX out_valid asserts 2 cycles after acceptance when unstalled.
REQ-022 SHALL sustain one accepted beat per cycle while out_ready is high.
REQ-023 SHALL drive in_ready = ~s1_valid | s1_advance, where s1_advance = ~s2_valid | out_ready; no combinational path from in_valid to in_ready.
REQ-024 SHALL hold result/nv/out_valid stable while out_valid & ~out_ready.
REQ-025 SHALL hold a reduction accumulator (acc, acc_nv) updated in stage 2: acc <= minmax(acc, a), acc_nv <= acc_nv | a_is_snan.
REQ-026 SHALL initialise acc to canonical qNaN and acc_nv to 0, so an all-NaN reduction yields canonical qNaN.
REQ-027 SHALL produce no output for non-last reduction beats; a last beat SHALL emit minmax(acc,a) with accumulated nv, then reinitialise acc/acc_nv in the same cycle.
REQ-028 SHALL leave acc untouched by interleaved FMIN/FMAX beats; results exit in acceptance order.
REQ-029 SHALL use the op of each individual beat; mixing REDMIN and REDMAX within one reduction applies each beat's own op.

Reset
REQ-030 SHALL, on rst, clear s1_valid, s2_valid, out_valid, nv, result (0), set acc to canonical qNaN, acc_nv 0, immediately and asynchronously.
REQ-031 SHALL discard any in-flight beat and partial reduction on reset mid-operation; in_ready SHALL be 1 in the first cycle after rst deasserts.

Structure
REQ-032 SHALL place op encodings, canonical-NaN constant builder and class struct in shared package fp_pkg.
REQ-033 SHALL instantiate sub-module fp_classify (per operand: is_nan, is_snan, is_zero, sign) twice in stage 1.
REQ-034 SHALL be 120-400 lines of RTL, no multi-cycle paths.

Verification
REQ-035 SHALL cover FMAX(0x00000000, 0x80000000) -> 0x00000000, nv=0, out_valid exactly 2 cycles after accept.
REQ-036 SHALL cover FMIN(0x7F800001, 0x3F800000) -> 0x3F800000, nv=1; FMAX(0x7FC00000, 0xFFC00001) -> 0x7FC00000, nv=0.
REQ-037 SHALL cover REDMAX beats 0x3F800000, 0xC0000000, 0x40400000(last) -> single output 0x40400000, nv=0.
REQ-038 SHALL cover REDMIN beats 0x7F800001, 0x7FC00000(last) -> 0x7FC00000, nv=1.
REQ-039 SHALL cover out_ready low 5 cycles with 3 FMAX beats offered -> in_ready drops after 2 accepted, no loss, order preserved.
REQ-040 SHALL cover rst pulse after 2 of 3 REDMAX beats, then REDMAX 0xC0000000(last) -> 0xC0000000 (no stale acc).
